// File: rtl/dice_pkg.sv
// Shared types and 7-segment face constants for the D4 roller display blocks.
package dice_pkg;

  // Active-low gfedcba patterns the roller drives for each face.
  localparam logic [6:0] SEG_D1    = 7'h79;
  localparam logic [6:0] SEG_D2    = 7'h24;
  localparam logic [6:0] SEG_D3    = 7'h30;
  localparam logic [6:0] SEG_D4    = 7'h19;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SETTLE,
    REPORT
  } tally_state_t;

  typedef logic [2:0] face_t;

endpackage

// File: rtl/seg7_to_face.sv
// Combinational 7-segment to die-face decoder; valid=0 for any pattern that is not a face.
module seg7_to_face
  import dice_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output face_t      face
);

  always_comb begin
    valid = 1'b1;
    face  = 3'd0;
    case (seg)
      SEG_D1:  face = 3'd1;
      SEG_D2:  face = 3'd2;
      SEG_D3:  face = 3'd3;
      SEG_D4:  face = 3'd4;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_roll_tally.sv
// Watches the roller's seg/roll lines, decodes each settled roll and keeps
// saturating per-face, total and error tallies.
module seg_roll_tally
  import dice_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  input  logic             roll_in,
  input  logic             clear,
  input  logic [1:0]       cnt_sel,
  output logic             roll_valid,
  output logic [2:0]       roll_value,
  output logic             invalid_seg,
  output logic [CNT_W-1:0] cnt_out,
  output logic [CNT_W+1:0] total_rolls,
  output logic [CNT_W-1:0] err_count
);

  localparam int                STAB_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  tally_state_t      state_q, state_d;
  logic [6:0]        seg_q, seg_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              roll_valid_q, roll_valid_d;
  logic              invalid_seg_q, invalid_seg_d;
  face_t             roll_value_q, roll_value_d;
  logic [CNT_W-1:0]  face_cnt_q [4];
  logic [CNT_W-1:0]  face_cnt_d [4];
  logic [CNT_W+1:0]  total_q, total_d;
  logic [CNT_W-1:0]  err_q, err_d;

  logic              dec_valid;
  face_t             dec_face;
  logic [1:0]        face_idx;
  logic              seg_same;
  logic              stab_done;
  logic              enter_report;

  // Decode the held sample; it equals seg_in whenever a report is taken.
  seg7_to_face u_dec (
    .seg   (seg_q),
    .valid (dec_valid),
    .face  (dec_face)
  );

  assign face_idx     = 2'(dec_face - 3'd1);
  assign seg_same     = (seg_in == seg_q);
  assign stab_done    = (stab_q == STAB_LAST);
  assign enter_report = (state_q == SETTLE) && !roll_in && seg_same && stab_done && !clear;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: all clocked state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d = state_q;
    case (state_q)
      IDLE:   if (roll_in) state_d = ARMED;
      ARMED:  if (!roll_in) state_d = SETTLE;
      SETTLE: begin
        if (roll_in)                     state_d = ARMED;
        else if (seg_same && stab_done)  state_d = REPORT;
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // Datapath and registered outputs.
  always_comb begin
    seg_d         = seg_q;
    stab_d        = stab_q;
    roll_valid_d  = 1'b0;
    invalid_seg_d = 1'b0;
    roll_value_d  = roll_value_q;
    face_cnt_d    = face_cnt_q;
    total_d       = total_q;
    err_d         = err_q;

    if (clear) begin
      seg_d        = SEG_BLANK;
      stab_d       = '0;
      roll_value_d = 3'd1;
      for (int i = 0; i < 4; i++) face_cnt_d[i] = '0;
      total_d      = '0;
      err_d        = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (!roll_in) begin
            seg_d  = seg_in;
            stab_d = '0;
          end
        end
        SETTLE: begin
          if (!roll_in) begin
            if (!seg_same) begin
              seg_d  = seg_in;
              stab_d = '0;
            end else if (!stab_done) begin
              stab_d = stab_q + 1'b1;
            end
          end
        end
        default: ;
      endcase

      // Tallies saturate at all-ones rather than wrapping.
      if (enter_report) begin
        if (dec_valid) begin
          roll_valid_d = 1'b1;
          roll_value_d = dec_face;
          if (face_cnt_q[face_idx] != '1) face_cnt_d[face_idx] = face_cnt_q[face_idx] + 1'b1;
          if (total_q != '1)              total_d = total_q + 1'b1;
        end else begin
          invalid_seg_d = 1'b1;
          if (err_q != '1) err_d = err_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q         <= SEG_BLANK;
      stab_q        <= '0;
      roll_valid_q  <= 1'b0;
      invalid_seg_q <= 1'b0;
      roll_value_q  <= 3'd1;
      // NOTE: the face array is four small counters in flops, not a RAM, so it
      // is reset along with the rest of the state.
      for (int i = 0; i < 4; i++) face_cnt_q[i] <= '0;
      total_q       <= '0;
      err_q         <= '0;
    end else begin
      seg_q         <= seg_d;
      stab_q        <= stab_d;
      roll_valid_q  <= roll_valid_d;
      invalid_seg_q <= invalid_seg_d;
      roll_value_q  <= roll_value_d;
      face_cnt_q    <= face_cnt_d;
      total_q       <= total_d;
      err_q         <= err_d;
    end
  end

  assign roll_valid  = roll_valid_q;
  assign roll_value  = roll_value_q;
  assign invalid_seg = invalid_seg_q;
  assign cnt_out     = face_cnt_q[cnt_sel];
  assign total_rolls = total_q;
  assign err_count   = err_q;

endmodule
